operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  serial beat qualifier from the host.
REQ-005 in_data  input  4  one operand nibble per beat, order n0..n5.
REQ-006 in_opt  input  3  operation code, sampled on beat 0 only.
REQ-007 in_equ  input  1  equation select, sampled on beat 0 only.
REQ-008 in_ready  output  1  high when the block accepts a new beat.
REQ-009 in_n0..in_n5  output  4 each  registered operands to the downstream sort/compute stage.
REQ-010 opt  output  3  registered opcode to the compute stage.
REQ-011 equ  output  1  registered equation select to the compute stage.
REQ-012 out_n  input  10  combinational result returned by the compute stage.
REQ-013 out_valid  output  1  one-cycle result strobe.
REQ-014 out_data  output  10  captured result, valid only with out_valid.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, EXEC and OUT.
REQ-016 in_ready SHALL be high in IDLE and LOAD and low in EXEC and OUT.
REQ-017 In IDLE, when in_valid=1, the block SHALL capture in_data into in_n0, latch in_opt and in_equ, set the beat count to 1 and enter LOAD.
REQ-018 In LOAD, each cycle with in_valid=1 SHALL write in_data into operand[beat count] and increment the 3-bit count.
REQ-019 After operand 5 is captured (6th beat), the FSM SHALL enter EXEC.
REQ-020 in_valid=0 during LOAD SHALL abort the load: return to IDLE, keep out_valid=0, and discard the partial operands with no result produced.
REQ-021 in_opt and in_equ on beats 1..5 SHALL be ignored.
REQ-022 EXEC SHALL last exactly one cycle with operands, opt and equ held stable; out_n SHALL be registered into out_data at the end of EXEC.
REQ-023 OUT SHALL last exactly one cycle with out_valid=1, then return to IDLE.
REQ-024 Latency SHALL be fixed: last beat at cycle t gives out_valid at cycle t+2.
REQ-025 out_data SHALL be 0 whenever out_valid=0.
REQ-026 in_valid during EXEC or OUT SHALL be ignored with no state change.
REQ-027 Operand outputs SHALL hold their last values after OUT until the next beat 0 overwrites them.
REQ-028 A new transaction MAY start in the cycle immediately after OUT (back-to-back); the minimum period is 8 cycles.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL set: state IDLE, beat count 0, in_n0..in_n5=0, opt=0, equ=0, out_valid=0, out_data=0.
REQ-030 Reset SHALL override in_valid in the same cycle.
REQ-031 Reset asserted mid-LOAD or mid-EXEC SHALL abort the transaction with no out_valid pulse afterwards.
REQ-032 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Structure
REQ-033 A shared package SHALL hold the state enum, NUM_OPERANDS=6, OPERAND_W=4, OPT_W=3 and RESULT_W=10.
REQ-034 No sub-module SHALL be instantiated; the compute stage is instantiated beside this block by the parent.
REQ-035 The beat counter and FSM SHALL be the only control state.

Verification
REQ-036 Beats 1,2,3,4,5,6 with opt=0, equ=0, real compute stage -> out_valid 2 cycles after the last beat, out_data=31.
REQ-037 Same operands with opt=0, equ=1 -> out_data=5.
REQ-038 in_valid dropped after beat 3 -> no out_valid; a following full load completes normally.
REQ-039 rst pulsed during EXEC -> out_valid stays 0 and all outputs read 0 on the next cycle.
REQ-040 Two back-to-back loads, with in_valid held high through EXEC/OUT -> beats during EXEC/OUT are ignored, and each completed load gives exactly one out_valid pulse with the correct result.
REQ-041 Beat 0 with opt=3'b101, later beats with opt=3'b010 -> opt output=3'b101 throughout EXEC.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types and sizing for the operand loader and its neighbours.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Contents:
//   NUM_OPERANDS, OPERAND_W, OPT_W, RESULT_W  - datapath sizing
//   CNT_W, LAST_IDX                           - beat counter sizing
//   state_e                                   - loader FSM states
//   accepts_beats()                           - states in which in_ready is high
package operand_loader_pkg;

  localparam int NUM_OPERANDS = 6;
  localparam int OPERAND_W    = 4;
  localparam int OPT_W        = 3;
  localparam int RESULT_W     = 10;

  // The beat counter is 3 bits wide, which covers operand indices 0..5.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPERANDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // The host may only push beats while the loader is collecting operands.
  function automatic logic accepts_beats(input state_e st);
    return (st == ST_IDLE) || (st == ST_LOAD);
  endfunction

endpackage

// File: rtl/operand_loader.sv
// Collects six serial operand nibbles plus opcode/equation select, presents
// them to the compute stage, then captures the compute result.
// Latency: last beat at cycle t -> out_valid at cycle t+2 (one EXEC, one OUT).
// Backpressure: in_ready drops during EXEC and OUT; beats offered then are ignored.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_data    - serial operand beats, n0 first
//   in_opt/in_equ       - opcode and equation select, taken from beat 0 only
//   in_ready            - high while beats are accepted (IDLE, LOAD)
//   in_n0..in_n5        - registered operands to the compute stage
//   opt/equ             - registered opcode / equation select to the compute stage
//   out_n               - combinational result coming back from the compute stage
//   out_valid/out_data  - one-cycle result strobe and captured result (0 otherwise)
module operand_loader
  import operand_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [OPERAND_W-1:0] in_data,
  input  logic [OPT_W-1:0]     in_opt,
  input  logic                 in_equ,
  output logic                 in_ready,
  output logic [OPERAND_W-1:0] in_n0,
  output logic [OPERAND_W-1:0] in_n1,
  output logic [OPERAND_W-1:0] in_n2,
  output logic [OPERAND_W-1:0] in_n3,
  output logic [OPERAND_W-1:0] in_n4,
  output logic [OPERAND_W-1:0] in_n5,
  output logic [OPT_W-1:0]     opt,
  output logic                 equ,
  input  logic [RESULT_W-1:0]  out_n,
  output logic                 out_valid,
  output logic [RESULT_W-1:0]  out_data
);

  // Control state: FSM plus beat counter, nothing else.
  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Datapath registers.
  logic [OPERAND_W-1:0] ops [NUM_OPERANDS];

  // Per-cycle write controls derived from the FSM.
  logic               capture;
  logic               first_beat;
  logic [CNT_W-1:0]   wr_idx;

  assign in_ready = accepts_beats(state);

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    first_beat = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          capture    = 1'b1;
          first_beat = 1'b1;
          cnt_nxt    = CNT_W'(1);
          state_nxt  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          capture = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = ST_EXEC;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          // A gap in the beat stream abandons the transaction; the partial
          // operands stay on the outputs but no result is ever produced.
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end

      ST_EXEC: begin
        state_nxt = ST_OUT;
      end

      ST_OUT: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat 0 always lands in slot 0, independent of whatever the counter holds.
  assign wr_idx = first_beat ? '0 : cnt;

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        ops[i] <= '0;
      end
      opt       <= '0;
      equ       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (capture) begin
        ops[wr_idx] <= in_data;
      end

      // Opcode and equation select only ever come from beat 0.
      if (first_beat) begin
        opt <= in_opt;
        equ <= in_equ;
      end

      // The compute stage sees stable operands throughout EXEC, so its
      // result is sampled on the edge that leaves EXEC. Outside OUT the
      // result register is forced to zero.
      out_valid <= (state == ST_EXEC);
      out_data  <= (state == ST_EXEC) ? out_n : '0;
    end
  end

  assign in_n0 = ops[0];
  assign in_n1 = ops[1];
  assign in_n2 = ops[2];
  assign in_n3 = ops[3];
  assign in_n4 = ops[4];
  assign in_n5 = ops[5];

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;
  import operand_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic [2:0] in_opt = '0;
  logic       in_equ = 1'b0;
  logic       in_ready;
  logic [3:0] in_n0, in_n1, in_n2, in_n3, in_n4, in_n5;
  logic [2:0] opt;
  logic       equ;
  logic [9:0] out_n;
  logic       out_valid;
  logic [9:0] out_data;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  operand_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_opt(in_opt), .in_equ(in_equ),
    .in_ready(in_ready),
    .in_n0(in_n0), .in_n1(in_n1), .in_n2(in_n2),
    .in_n3(in_n3), .in_n4(in_n4), .in_n5(in_n5),
    .opt(opt), .equ(equ),
    .out_n(out_n), .out_valid(out_valid), .out_data(out_data)
  );

  // Stand-in compute stage sitting beside the loader:
  //   equ=0 : n5*n4 + n0 + opt
  //   equ=1 : |n5 - n0| + opt
  function automatic logic [9:0] compute(input logic [3:0] a0, input logic [3:0] a4,
                                         input logic [3:0] a5, input logic [2:0] o,
                                         input logic e);
    int r;
    if (e) r = (a5 > a0) ? int'(a5) - int'(a0) : int'(a0) - int'(a5);
    else   r = int'(a5) * int'(a4) + int'(a0);
    r = r + int'(o);
    return r[9:0];
  endfunction

  assign out_n = compute(in_n0, in_n4, in_n5, opt, equ);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Transaction-level model: beats accumulate in a queue; the sixth beat
  // schedules a result two cycles later, and the two cycles ending at that
  // result are closed to new beats.
  // ------------------------------------------------------------------
  int         cyc = 0;
  int         due = -1;
  int         n_end;
  int         q[$];
  logic [3:0] m_n [6];
  logic [2:0] m_opt;
  logic       m_equ;
  logic [9:0] m_res;
  bit         armed = 1'b0;

  function automatic bit closed(input int c);
    return (due >= 0) && (c == due - 1 || c == due);
  endfunction

  always @(posedge clk) begin
    n_end = cyc;
    if (rst) begin
      armed = 1'b1;
      due = -1;
      q.delete();
      for (int i = 0; i < 6; i++) m_n[i] = '0;
      m_opt = '0;
      m_equ = 1'b0;
      m_res = '0;
    end else if (!closed(n_end)) begin
      if (in_valid) begin
        if (q.size() == 0) begin
          m_opt = in_opt;
          m_equ = in_equ;
        end
        m_n[q.size()] = in_data;
        q.push_back(int'(in_data));
        if (q.size() == 6) begin
          due = n_end + 2;
          m_res = compute(m_n[0], m_n[4], m_n[5], m_opt, m_equ);
          q.delete();
        end
      end else begin
        q.delete();
      end
    end
    cyc = cyc + 1;
  end

  // Compare process: every cycle once reset has been seen.
  logic [3:0] dut_n [6];
  assign dut_n[0] = in_n0;
  assign dut_n[1] = in_n1;
  assign dut_n[2] = in_n2;
  assign dut_n[3] = in_n3;
  assign dut_n[4] = in_n4;
  assign dut_n[5] = in_n5;

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", int'(in_ready), int'(!closed(cyc)));
      chk("out_valid", int'(out_valid), int'(due >= 0 && cyc == due));
      chk("out_data", int'(out_data), (due >= 0 && cyc == due) ? int'(m_res) : 0);
      for (int i = 0; i < 6; i++) chk($sformatf("in_n%0d", i), int'(dut_n[i]), int'(m_n[i]));
      chk("opt", int'(opt), int'(m_opt));
      chk("equ", int'(equ), int'(m_equ));
    end
    if (out_valid === 1'b1) pulses++;
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic drive(input logic v, input logic [3:0] d, input logic [2:0] o, input logic e);
    @(negedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_opt   = o;
    in_equ   = e;
  endtask

  // ds holds n0 in its low nibble; beat 0 carries o0/e0, later beats orest/erest.
  task automatic load6(input logic [23:0] ds, input logic [2:0] o0, input logic e0,
                       input logic [2:0] orest, input logic erest);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(1'b1, ds[3:0], o0, e0);
      else        drive(1'b1, ds[4*i +: 4], orest, erest);
    end
  endtask

  // Called right after the last beat is driven; stops the beat stream and
  // checks the fixed latency, the result and optionally opt during EXEC.
  task automatic wait_result(input string nm, input int exp_dat,
                             input bit check_opt, input int exp_opt);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1 && check_opt) chk({nm, "_opt_exec"}, int'(opt), exp_opt);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_data"}, int'(out_data), exp_dat);
      end
      #1 in_valid = 1'b0;
    end
    chk({nm, "_latency"}, k, 2);
  endtask

  int p0;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_n0", int'(in_n0), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Operands 1..6, opt=0, equ=0; later beats carry junk opt/equ.
    load6(24'h654321, 3'd0, 1'b0, 3'd7, 1'b1);
    wait_result("r_equ0", 31, 1'b1, 0);

    // Same operands, equ=1.
    load6(24'h654321, 3'd0, 1'b1, 3'd0, 1'b0);
    wait_result("r_equ1", 5, 1'b0, 0);

    // opt from beat 0 held through EXEC: 6*5+1+5.
    load6(24'h654321, 3'b101, 1'b0, 3'b010, 1'b0);
    wait_result("r_opt", 36, 1'b1, 5);

    // Abort after beat 3, then a full load: 9*7+2+1.
    p0 = pulses;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd8, 3'd4, 1'b1);
    drive(1'b0, 4'd0, 3'd0, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_no_pulse", pulses - p0, 0);
    load6(24'h970002, 3'd1, 1'b0, 3'd0, 1'b0);
    wait_result("r_after_abort", 66, 1'b0, 0);

    // Reset during EXEC.
    p0 = pulses;
    load6(24'h123456, 3'd2, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    chk("exec_in_ready", int'(in_ready), 0);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_exec_out_valid", int'(out_valid), 0);
    chk("rst_exec_out_data", int'(out_data), 0);
    chk("rst_exec_in_n0", int'(in_n0), 0);
    chk("rst_exec_in_n5", int'(in_n5), 0);
    chk("rst_exec_opt", int'(opt), 0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_exec_no_pulse", pulses - p0, 0);

    // Back-to-back loads with in_valid held high through EXEC/OUT.
    p0 = pulses;
    load6(24'h951413, 3'd2, 1'b1, 3'd0, 1'b0);
    drive(1'b1, 4'hF, 3'd6, 1'b0);
    drive(1'b1, 4'hF, 3'd6, 1'b0);
    load6(24'hABCDEF, 3'd7, 1'b0, 3'd1, 1'b1);
    wait_result("r_b2b_second", 132, 1'b1, 7);
    repeat (3) @(negedge clk);
    chk("b2b_pulse_count", pulses - p0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
